// File: rtl/mem_model_pkg.sv
// mem_model_pkg: shared constants and types for the timed line memory.
// Holds parameter defaults, the line-offset helper and LFSR constants.
package mem_model_pkg;

    localparam int DEF_LINE_W  = 128;
    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_INDEX_W = 6;
    localparam int DEF_LATENCY = 5;
    localparam int DEF_ID_W    = 1;
    localparam int DEF_QDEPTH  = 4;

    // Fibonacci taps 16,14,13,11 as a mask over lfsr[15:0]
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Byte-offset bits below the line index
    function automatic int line_off(input int line_w);
        return $clog2(line_w / 8);
    endfunction

    typedef struct packed {
        logic [DEF_ID_W-1:0]   id;
        logic [DEF_LINE_W-1:0] data;
    } rsp_t;

endpackage

// File: rtl/timed_line_memory_if.sv
// timed_line_memory_if: request/response handshake bundle.
// master = client side, slave = memory side.
interface timed_line_memory_if
    import mem_model_pkg::*;
#(
    parameter int LINE_W = DEF_LINE_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int ID_W   = DEF_ID_W
);
    logic              req_valid;
    logic              req_ready;
    logic              req_wren;
    logic [ADDR_W-1:0] req_addr;
    logic [LINE_W-1:0] req_data;
    logic [ID_W-1:0]   req_id;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [LINE_W-1:0] rsp_data;
    logic [ID_W-1:0]   rsp_id;

    modport master (
        output req_valid, req_wren, req_addr, req_data, req_id,
        output rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_id
    );

    modport slave (
        input  req_valid, req_wren, req_addr, req_data, req_id,
        input  rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_id
    );

endinterface

// File: rtl/timed_line_memory_sync_fifo.sv
// sync_fifo: show-ahead synchronous FIFO, storage cleared on reset.
// Push when full and pop when empty are ignored.
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push;
    logic          do_pop;

    assign full    = (cnt_q == CW'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem_q[rd_q];

    // Next storage, pointers and fill count
    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        if (do_push) begin
            mem_d[wr_q] = din;
            wr_d = (wr_q == LAST) ? '0 : wr_q + AW'(1);
        end
        if (do_pop) begin
            rd_d = (rd_q == LAST) ? '0 : rd_q + AW'(1);
        end
        cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end

    // State registers
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q <= '{default: '0};
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/timed_line_memory.sv
// timed_line_memory: stored line memory with fixed read latency and a
// credit-limited response FIFO. Optional macro: STALL_INJECT_EN.
module timed_line_memory
    import mem_model_pkg::*;
#(
    parameter int LINE_W  = DEF_LINE_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int INDEX_W = DEF_INDEX_W,
    parameter int LATENCY = DEF_LATENCY,
    parameter int ID_W    = DEF_ID_W,
    parameter int QDEPTH  = DEF_QDEPTH
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic busy,
    timed_line_memory_if.slave bus
);
    localparam int OFF   = line_off(LINE_W);
    localparam int DEPTH = 2 ** INDEX_W;
    localparam int STG   = (LATENCY > 1) ? LATENCY - 1 : 1;
    localparam int OW    = $clog2(QDEPTH + 1);

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [LINE_W-1:0] data;
    } line_rsp_t;

    localparam int RW = $bits(line_rsp_t);

    logic [LINE_W-1:0]  mem_q [DEPTH];
    logic [LINE_W-1:0]  mem_d [DEPTH];
    logic [STG-1:0]     pipe_v_q, pipe_v_d;
    line_rsp_t          pipe_q [STG];
    line_rsp_t          pipe_d [STG];
    logic [OW-1:0]      out_q, out_d;
    logic [INDEX_W-1:0] idx;
    logic               accept;
    logic               rd_acc;
    logic               wr_acc;
    logic               stall;
    logic               last_v;
    logic               push;
    logic               pop;
    logic               fifo_full;
    logic               fifo_empty;
    line_rsp_t          in_rsp;
    line_rsp_t          last_rsp;
    line_rsp_t          head;
    logic               unused_addr;

    assign unused_addr = ^bus.req_addr;
    assign idx         = bus.req_addr[OFF +: INDEX_W];

    assign bus.req_ready = en & ~reset & ~stall
                         & (out_q < OW'(QDEPTH));
    assign accept = bus.req_valid & bus.req_ready;
    assign rd_acc = accept & ~bus.req_wren;
    assign wr_acc = accept & bus.req_wren;

    assign in_rsp.id   = bus.req_id;
    assign in_rsp.data = mem_q[idx];

    assign last_v   = (LATENCY > 1) ? pipe_v_q[STG-1] : rd_acc;
    assign last_rsp = (LATENCY > 1) ? pipe_q[STG-1] : in_rsp;
    assign push     = en & last_v;

    assign bus.rsp_valid = en & ~fifo_empty;
    assign pop           = bus.rsp_valid & bus.rsp_ready;
    assign bus.rsp_data  = head.data;
    assign bus.rsp_id    = head.id;
    assign busy          = (out_q != '0);

`ifdef STALL_INJECT_EN
    logic [15:0] lfsr_q, lfsr_d;

    // LFSR steps on every enabled cycle
    always_comb begin
        lfsr_d = lfsr_q;
        if (en) begin
            lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
        end
    end

    // LFSR register
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign stall = (lfsr_q[1:0] == 2'b00);
`else
    assign stall = 1'b0;
`endif

    // Array write on accepted write request
    always_comb begin
        mem_d = mem_q;
        if (wr_acc) begin
            mem_d[idx] = bus.req_data;
        end
    end

    // Latency pipeline shifts only while enabled
    always_comb begin
        pipe_v_d = pipe_v_q;
        pipe_d   = pipe_q;
        if (en) begin
            pipe_v_d[0] = rd_acc;
            pipe_d[0]   = in_rsp;
            for (int i = 1; i < STG; i++) begin
                pipe_v_d[i] = pipe_v_q[i-1];
                pipe_d[i]   = pipe_q[i-1];
            end
        end
    end

    // Read credits: up on read accept, down on pop
    always_comb begin
        out_d = out_q;
        unique case ({rd_acc, pop})
            2'b10:   out_d = out_q + OW'(1);
            2'b01:   out_d = out_q - OW'(1);
            default: out_d = out_q;
        endcase
    end

    // Storage, pipeline and credit registers
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q    <= '{default: '0};
            pipe_v_q <= '0;
            pipe_q   <= '{default: '0};
            out_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            pipe_v_q <= pipe_v_d;
            pipe_q   <= pipe_d;
            out_q    <= out_d;
        end
    end

    sync_fifo #(
        .W     (RW),
        .DEPTH (QDEPTH)
    ) u_rsp_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (last_rsp),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Credits guarantee the queue never overflows
    a_no_overflow: assert property (
        @(posedge clk) disable iff (reset) !(push && fifo_full)
    ) else $error("response fifo overflow");

endmodule
